// File: rtl/key_pkg.sv
// Shared types and default timing constants for the DE2 push-button conditioner.
package key_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 10;   // 100 ms

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One button: two-flop synchronizer, debounce counter, edge pulses and hold-to-repeat FSM.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DB_W-1:0]  DB_TERM     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] DELAY_TERM  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_TERM = TMR_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             accept_s, press_s, release_s;
  key_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             step_d;
  logic             level_q, press_q, release_q, step_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter reaching DB_TERM means the next mismatch cycle is the accepting one.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    accept_s = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_TERM) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
        accept_s = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign press_s   = accept_s & ~sync2_q;
  assign release_s = accept_s &  sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b1;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (release_s) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_d = '0;
          if (press_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (tmr_q == DELAY_TERM) begin
            state_d = ST_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_REPEAT: begin
          if (tmr_q == PERIOD_TERM) begin
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_d = 1'b0;
    if (!release_s) begin
      case (state_q)
        ST_IDLE:   step_d = press_s;
        ST_HOLD:   step_d = (tmr_q == DELAY_TERM);
        ST_REPEAT: step_d = (tmr_q == PERIOD_TERM);
        default:   step_d = 1'b0;
      endcase
    end else begin
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      level_q   <= ~stable_d;
      press_q   <= press_s;
      release_q <= release_s;
      step_q    <= step_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low DE2 buttons into level, press, release and step pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_step
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i    (CLOCK_50),
      .rst_ni   (rst_n),
      .key_n_i  (key_n[k]),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k]),
      .step_o   (key_step[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with an event-level model of debounce and repeat timing.
module tb_key_debounce;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       CLOCK_50;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] key_level, key_press, key_release, key_step;

  key_debounce #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_step   (key_step)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int key;
    int kind;      // 0 press, 1 release, 2 step
    int edge_no;
  } ev_t;

  ev_t        evq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ecount = 0;
  logic [3:0] m_dly1, m_dly2, m_lvl;
  int         m_run[4];
  int         m_tpress[4];
  logic [3:0] e_press, e_rel, e_step;

  task automatic model_reset();
    m_dly1 = 4'hF; m_dly2 = 4'hF; m_lvl = 4'h0;
    e_press = 4'h0; e_rel = 4'h0; e_step = 4'h0;
    for (int k = 0; k < 4; k++) begin
      m_run[k] = 0; m_tpress[k] = 0;
    end
  endtask

  // A level is accepted after DB+1 consecutive disagreeing samples seen two edges late.
  task automatic model_step(input logic [3:0] raw);
    logic [3:0] seen;
    int d;
    seen = m_dly2;
    m_dly2 = m_dly1;
    m_dly1 = raw;
    e_press = 4'h0; e_rel = 4'h0; e_step = 4'h0;
    for (int k = 0; k < 4; k++) begin
      if (seen[k] == m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DB + 1) begin
          m_run[k] = 0;
          m_lvl[k] = ~m_lvl[k];
          if (m_lvl[k]) begin
            e_press[k] = 1'b1; e_step[k] = 1'b1; m_tpress[k] = ecount;
            evq.push_back('{k, 0, ecount});
            evq.push_back('{k, 2, ecount});
          end else begin
            e_rel[k] = 1'b1;
            evq.push_back('{k, 1, ecount});
          end
        end
      end else begin
        m_run[k] = 0;
      end
      if (m_lvl[k] && !e_press[k]) begin
        d = ecount - m_tpress[k];
        if (d == RD || (d > RD && ((d - RD) % RP) == 0)) begin
          e_step[k] = 1'b1;
          evq.push_back('{k, 2, ecount});
        end
      end
    end
  endtask

  task automatic cmp4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, ecount, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int rel_event(input int key, input int kind, input int base, input int n);
    int c = 0;
    foreach (evq[i]) begin
      if (evq[i].key == key && evq[i].kind == kind && evq[i].edge_no >= base) begin
        if (c == n) return evq[i].edge_no - base;
        c++;
      end
    end
    return -1;
  endfunction

  // Per-cycle comparison of the DUT against the model, just after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK_50);
      ecount++;
      if (!rst_n) model_reset();
      else model_step(key_n);
      #1;
      cmp4("level",   key_level,   m_lvl);
      cmp4("press",   key_press,   e_press);
      cmp4("release", key_release, e_rel);
      cmp4("step",    key_step,    e_step);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    key_n = 4'h0;
    tick(5);
    cmp4("reset_level", key_level, 4'h0);
    cmp4("reset_step",  key_step,  4'h0);

    // Keys held through reset release are new presses six edges later.
    rst_n = 1'b1; base = ecount + 1;
    tick(8);
    for (int k = 0; k < 4; k++) check_int("deassert_press_lat", rel_event(k, 0, base, 0), 6);
    key_n = 4'hF;
    tick(24);

    key_n = 4'b1110; base = ecount + 1;
    tick(9);
    check_int("clean_press_lat", rel_event(0, 0, base, 0), 6);
    check_int("clean_step_lat",  rel_event(0, 2, base, 0), 6);
    check_int("clean_other_key", rel_event(1, 0, base, 0), -1);
    key_n = 4'hF;
    tick(14);

    base = ecount + 1;
    for (int r = 0; r < 5; r++) begin
      key_n = 4'b1101; tick(3);
      key_n = 4'hF;    tick(1);
    end
    tick(12);
    check_int("bounce_no_press",   rel_event(1, 0, base, 0), -1);
    check_int("bounce_no_release", rel_event(1, 1, base, 0), -1);
    cmp4("bounce_level", key_level, 4'h0);

    // Repeats keep coming until the debounced release lands at edge 32.
    key_n = 4'b1011; base = ecount + 1;
    tick(26);
    key_n = 4'hF;
    tick(14);
    check_int("hold_step0", rel_event(2, 2, base, 0), 6);
    check_int("hold_step1", rel_event(2, 2, base, 1), 16);
    check_int("hold_step2", rel_event(2, 2, base, 2), 19);
    check_int("hold_step3", rel_event(2, 2, base, 3), 22);
    check_int("hold_step4", rel_event(2, 2, base, 4), 25);
    check_int("hold_step5", rel_event(2, 2, base, 5), 28);
    check_int("hold_step6", rel_event(2, 2, base, 6), 31);
    check_int("hold_no_more", rel_event(2, 2, base, 7), -1);
    check_int("hold_release", rel_event(2, 1, base, 0), 32);

    key_n = 4'b0110; base = ecount + 1;
    tick(23);
    check_int("simul_press0", rel_event(0, 0, base, 0), 6);
    check_int("simul_press3", rel_event(3, 0, base, 0), 6);
    for (int n = 0; n < 4; n++)
      check_int("simul_cadence", rel_event(3, 2, base, n), rel_event(0, 2, base, n));
    check_int("simul_step3", rel_event(3, 2, base, 3), 22);
    key_n = 4'hF;
    tick(14);

    key_n = 4'b0111;
    tick(20);
    cmp4("pre_reset_level", key_level, 4'b1000);
    rst_n = 1'b0;
    #1;
    cmp4("async_rst_level", key_level, 4'h0);
    cmp4("async_rst_step",  key_step,  4'h0);
    tick(3);
    rst_n = 1'b1; base = ecount + 1;
    tick(9);
    check_int("rst_hold_press", rel_event(3, 0, base, 0), 6);
    key_n = 4'hF;
    tick(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
